// File: rtl/deemph_pkg.sv
// Shared constants and types for the stereo de-emphasis scheduler.
package deemph_pkg;

  localparam int COEF_FRAC = 17;
  localparam int B50_Q17   = 60914;  // 0.464739 * 2^17, 50 us at 32 kHz
  localparam int B75_Q17   = 44664;  // 0.340759 * 2^17, 75 us at 32 kHz

  typedef enum logic [2:0] {IDLE, DIFF, MUL, ACC, OUT} state_t;
  typedef enum logic {CH_L, CH_R} ch_t;

endpackage

// File: rtl/deemph_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// channel that was not served last.
module deemph_arb2
  import deemph_pkg::*;
(
  input  logic l_valid,
  input  logic r_valid,
  input  ch_t  last,
  output logic l_grant,
  output logic r_grant
);

  assign l_grant = l_valid & (~r_valid | (last == CH_R));
  assign r_grant = r_valid & (~l_valid | (last == CH_L));

endmodule

// File: rtl/deemph_scheduler.sv
// Time-multiplexed stereo de-emphasis: y += B*(x - y) per channel on one
// shared datapath. Define DEEMPH_TAU75_EN to add the tau75 coefficient select.
module deemph_scheduler
  import deemph_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int COEF_W = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] l_in,
  input  logic             l_valid,
  output logic             l_ready,
  input  logic [WIDTH-1:0] r_in,
  input  logic             r_valid,
  output logic             r_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_ch,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DEEMPH_TAU75_EN
  ,
  input  logic             tau75
`endif
);

  localparam int PW = WIDTH + COEF_W + 1;
  localparam logic signed [PW-1:0] ROUND = PW'(2 ** (COEF_FRAC - 1));
  localparam logic signed [PW-1:0] SMAX  = PW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [PW-1:0] SMIN  = -SMAX - PW'(1);
  localparam logic signed [COEF_W-1:0] COEF_B50 = COEF_W'(B50_Q17);
`ifdef DEEMPH_TAU75_EN
  localparam logic signed [COEF_W-1:0] COEF_B75 = COEF_W'(B75_Q17);
`endif

  state_t                    state;
  ch_t                       ch;
  ch_t                       last;
  logic signed [WIDTH-1:0]   x;
  logic signed [WIDTH-1:0]   y [2];
  logic signed [COEF_W-1:0]  coef;
  logic signed [WIDTH:0]     d;
  logic signed [PW-1:0]      p;
  logic                      l_grant;
  logic                      r_grant;
  logic signed [COEF_W-1:0]  coef_sel;
  logic signed [PW-1:0]      d_ext;
  logic signed [PW-1:0]      coef_ext;
  logic signed [PW-1:0]      p_rnd;
  logic signed [PW-1:0]      s;
  logic signed [WIDTH-1:0]   s_sat;

  deemph_arb2 u_arb (
    .l_valid (l_valid),
    .r_valid (r_valid),
    .last    (last),
    .l_grant (l_grant),
    .r_grant (r_grant)
  );

  // Readies depend only on registered state and the valids, never on out_ready.
  assign l_ready = (state == IDLE) & l_grant;
  assign r_ready = (state == IDLE) & r_grant;

`ifdef DEEMPH_TAU75_EN
  assign coef_sel = tau75 ? COEF_B75 : COEF_B50;
`else
  assign coef_sel = COEF_B50;
`endif

  always_comb begin
    d_ext    = PW'(d);
    coef_ext = PW'(coef);
    p_rnd    = (p + ROUND) >>> COEF_FRAC;
    s        = PW'(y[ch]) + p_rnd;
    s_sat    = s[WIDTH-1:0];
    if (s > SMAX) s_sat = SMAX[WIDTH-1:0];
    else if (s < SMIN) s_sat = SMIN[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ch        <= CH_L;
      last      <= CH_R;
      x         <= '0;
      y[0]      <= '0;
      y[1]      <= '0;
      coef      <= COEF_B50;
      d         <= '0;
      p         <= '0;
      out       <= '0;
      out_ch    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (l_ready) begin
            x     <= l_in;
            ch    <= CH_L;
            coef  <= coef_sel;
            state <= DIFF;
          end else if (r_ready) begin
            x     <= r_in;
            ch    <= CH_R;
            coef  <= coef_sel;
            state <= DIFF;
          end
        end
        DIFF: begin
          d     <= $signed({x[WIDTH-1], x}) - $signed({y[ch][WIDTH-1], y[ch]});
          state <= MUL;
        end
        MUL: begin
          p     <= d_ext * coef_ext;
          state <= ACC;
        end
        ACC: begin
          y[ch]     <= s_sat;
          out       <= s_sat;
          out_ch    <= ch;
          last      <= ch;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
